// File: rtl/sar_sync_ctrl.sv
// sar_sync_ctrl
// Synchronous SAR conversion controller. One state machine sequences the
// track phase, the DAC settle phase and the comparator strobe/decision phase
// for each bit, MSB first. It drives the differential cap DAC controls and
// publishes a registered result with a one-cycle valid pulse.
//
// Ports
//   clk         rising-edge clock for every register
//   rst_n       asynchronous active-low reset
//   start       request one conversion (looked at in IDLE only)
//   cont        continuous mode (looked at in DONE)
//   cmp_out     comparator decision, 1 means vp > vn
//   cmp_valid   comparator has finished evaluating
//   sample      high while the sample-and-hold tracks
//   cmp_strobe  one-cycle evaluate pulse, first cycle of each COMPARE visit
//   dac_data_h  DAC high-side controls (the p DAC takes h and l swapped)
//   dac_data_l  DAC low-side controls
//   adc_data    last result, MSB = bit ADC_BITS-1
//   data_valid  one-cycle pulse when adc_data updates
//   busy        high in every state except IDLE
//   meta_err    at least one bit of the last result was forced by timeout
module sar_sync_ctrl #(
    parameter int ADC_BITS    = 8,
    parameter int SAMPLE_CYC  = 4,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cont,
    input  logic                cmp_out,
    input  logic                cmp_valid,
    output logic                sample,
    output logic                cmp_strobe,
    output logic [ADC_BITS-2:0] dac_data_h,
    output logic [ADC_BITS-2:0] dac_data_l,
    output logic [ADC_BITS-1:0] adc_data,
    output logic                data_valid,
    output logic                busy,
    output logic                meta_err
);

    localparam int MAX_CYC_A = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int MAX_CYC   = (MAX_CYC_A > TIMEOUT_CYC) ? MAX_CYC_A : TIMEOUT_CYC;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);
    localparam int IDX_W     = $clog2(ADC_BITS);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(ADC_BITS - 1);
    localparam bit               NO_SETTLE   = (SETTLE_CYC == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [ADC_BITS-1:0] work;
    logic                tmo_flag;

    logic                decide;
    logic                dbit;
    logic                tmo_hit;
    logic                phase_change;

    // Next-state and per-cycle decision logic
    always_comb begin
        state_next = state;
        decide     = 1'b0;
        dbit       = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (cnt == SAMPLE_LAST) begin
                    state_next = NO_SETTLE ? S_COMPARE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // A real decision on the last allowed cycle beats the timeout.
                if (cmp_valid) begin
                    decide = 1'b1;
                    dbit   = cmp_out;
                end else if (cnt == TMO_LAST) begin
                    decide  = 1'b1;
                    dbit    = 1'b1;
                    tmo_hit = 1'b1;
                end
                if (decide) begin
                    if (idx == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = NO_SETTLE ? S_COMPARE : S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_next = cont ? S_SAMPLE : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A decision restarts the phase even when COMPARE follows COMPARE.
    assign phase_change = (state_next != state) || decide;

    // State, counters, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= IDX_MSB;
            work       <= '0;
            tmo_flag   <= 1'b0;
            sample     <= 1'b0;
            cmp_strobe <= 1'b0;
            dac_data_h <= '0;
            dac_data_l <= '0;
            adc_data   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            meta_err   <= 1'b0;
        end else begin
            state <= state_next;

            if (phase_change || (state == S_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            sample     <= (state_next == S_SAMPLE);
            busy       <= (state_next != S_IDLE);
            cmp_strobe <= (state_next == S_COMPARE) && phase_change;
            data_valid <= (state_next == S_DONE);

            if ((state_next == S_SAMPLE) && (state != S_SAMPLE)) begin
                // New conversion: DAC back to vcm, clear the working result.
                idx        <= IDX_MSB;
                work       <= '0;
                tmo_flag   <= 1'b0;
                dac_data_h <= '0;
                dac_data_l <= '0;
            end else if (decide) begin
                for (int b = 0; b < ADC_BITS; b++) begin
                    if (idx == IDX_W'(b)) begin
                        work[b] <= dbit;
                    end
                end
                // Bit i steers DAC element i-1; bit 0 drives nothing.
                for (int b = 0; b < ADC_BITS - 1; b++) begin
                    if (idx == IDX_W'(b + 1)) begin
                        dac_data_h[b] <= dbit;
                        dac_data_l[b] <= ~dbit;
                    end
                end
                tmo_flag <= tmo_flag | tmo_hit;
                if (idx != '0) begin
                    idx <= idx - 1'b1;
                end
            end

            if (decide && (idx == '0)) begin
                adc_data <= {work[ADC_BITS-1:1], dbit};
                meta_err <= tmo_flag | tmo_hit;
            end
        end
    end

endmodule

// File: doc/sar_sync_ctrl.md
# sar_sync_ctrl

Clocked, parametrised SAR conversion controller. It replaces the ideal asynchronous clock generator and SAR logic pair with one synchronous state machine. It sequences sample, DAC settle and comparator strobe phases, and adds programmable phase lengths, continuous-conversion mode and a per-bit comparator timeout with an error flag. It sits between the sample-and-hold, the two cap DACs (p and n paths) and the sense amplifier, and presents a registered result with a valid pulse to the digital back end.

## Interface
- ADC_BITS, 8: resolution, ≥2.
- SAMPLE_CYC, 4: cycles `sample` is held high, ≥1.
- SETTLE_CYC, 2: DAC settle cycles before each strobe, ≥0.
- TIMEOUT_CYC, 8: COMPARE cycles allowed before a forced decision, ≥1.

Ports:
- clk  in  1  single clock; every register is clocked on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  requests one conversion; sampled in IDLE only.
- cont  in  1  continuous mode; sampled in DONE.
- cmp_out  in  1  comparator decision; 1 means vp > vn.
- cmp_valid  in  1  comparator finished (senamp_done equivalent).
- sample  out  1  high during the track phase.
- cmp_strobe  out  1  one-cycle comparator evaluate pulse.
- dac_data_h  out  ADC_BITS-1  DAC high-side controls.
- dac_data_l  out  ADC_BITS-1  DAC low-side controls. The p DAC takes h and l swapped, as today.
- adc_data  out  ADC_BITS  last result, MSB = bit ADC_BITS-1.
- data_valid  out  1  one-cycle pulse when `adc_data` updates.
- busy  out  1  high in every state except IDLE.
- meta_err  out  1  set if any bit of the last result timed out.

## Operation
States:
- **IDLE**: waits for `start`.
- **SAMPLE**: holds `sample` high.
- **SETTLE**: waits for the DAC to settle.
- **COMPARE**: strobes the comparator and waits for a decision.
- **DONE**: publishes the result.

Transitions:
- IDLE → SAMPLE when `start`=1.
- SAMPLE → SETTLE after SAMPLE_CYC cycles.
- SETTLE → COMPARE after SETTLE_CYC cycles. With SETTLE_CYC=0, SAMPLE and COMPARE go straight to COMPARE and SETTLE is skipped.
- COMPARE → SETTLE (or COMPARE) when a decision is taken on bit index i>0.
- COMPARE → DONE when a decision is taken on bit index 0.
- DONE → SAMPLE if `cont`=1, otherwise DONE → IDLE.

Bit and DAC handling:
- Bit index i runs from ADC_BITS-1 down to 0 and is reloaded to ADC_BITS-1 on entering SAMPLE.
- `cmp_strobe`=1 only in the first cycle of each COMPARE visit.
- `cmp_valid` is sampled in every COMPARE cycle, including the strobe cycle.
- Decision d = `cmp_out` when `cmp_valid`=1.
- If TIMEOUT_CYC COMPARE cycles pass without `cmp_valid`, d=1 is forced and the internal timeout flag is set.
- On a decision for bit i, the working result bit i takes d.
- For i≥1, the same decision sets `dac_data_h`[i-1]=d and `dac_data_l`[i-1]=~d, both registered on that edge.
- Bit 0 drives no DAC element.
- On entering SAMPLE, `dac_data_h` and `dac_data_l` are cleared to all-zero (DAC at vcm), and the working register and timeout flag are cleared.

DONE cycle:
- `adc_data` ← working register.
- `meta_err` ← timeout flag.
- `data_valid`=1.

Boundary and hold rules:
- `start` outside IDLE is ignored, with no queueing.
- Clearing `cont` mid-conversion completes that conversion, then goes to IDLE.
- `adc_data` and `meta_err` hold their values until the next DONE.
- A `cmp_valid` outside COMPARE is ignored.
- When `cmp_valid` and timeout coincide, `cmp_valid` wins and there is no error.
- Reset asserted mid-conversion aborts it immediately, with no `data_valid`.

## Timing
Reset values:
- state = IDLE.
- `sample`, `cmp_strobe`, `data_valid`, `busy`, `meta_err` = 0.
- `dac_data_h`, `dac_data_l`, `adc_data` = 0.

Reset is asynchronous on assertion; release takes effect at the first clk edge with `rst_n`=1.

Outputs:
- All outputs are registered, so none is combinational from inputs.
- The `start` edge is edge 0. `sample` is high in cycles 1..SAMPLE_CYC.

Per-bit cost is SETTLE_CYC + k cycles, where k is the number of COMPARE cycles (1..TIMEOUT_CYC).

Conversion latency:
- With `cmp_valid` always high, `data_valid` rises in cycle SAMPLE_CYC + ADC_BITS·(SETTLE_CYC+1) + 1 after `start`.
- Defaults give cycle 29.

Continuous mode:
- `sample` rises the cycle after DONE.
- Throughput is one result every SAMPLE_CYC + ADC_BITS·(SETTLE_CYC+1) + 1 cycles.

## Test plan
- **Single conversion.** Defaults, `cmp_valid` tied 1, `cmp_out` sequence 1,0,1,1,0,0,1,0 → `adc_data`=8'hB2 and `data_valid` in cycle 29. `meta_err`=0, `busy` falls in cycle 30, and `dac_data_h` = 7'b1011001 at DONE.
- **DAC step check.** After the MSB decision of 1 → `dac_data_h`[6]=1 and `dac_data_l`[6]=0, with all other bits 0. Exactly one `cmp_strobe` pulse per bit, 8 in total.
- **Timeout.** `cmp_valid` withheld on bit 3 only → bit 3 forced to 1, that bit takes 2+8 cycles, `meta_err`=1 with `data_valid`. The next clean conversion returns `meta_err`=0.
- **Continuous mode.** `cont`=1 for two conversions → back-to-back `data_valid` pulses 29 cycles apart, with `sample` rising the cycle after each DONE. Clearing `cont` during the second conversion → return to IDLE after its DONE.
- **Reset mid-conversion.** `rst_n` low during bit 4 → all outputs zero in the same cycle, with no `data_valid`. A new `start` after release converts correctly.
- **Corner parameters.** ADC_BITS=2, SETTLE_CYC=0, SAMPLE_CYC=1: start, `cmp_out`=1,1 → `adc_data`=2'b11 in cycle 4. A `start` pulse during busy is ignored.
